// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM target port among N_REQ masters.
// An ID FIFO remembers the grant order so each response goes back to its issuer.
module tcdm_rr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    // master side
    input  logic [N_REQ-1:0]          in_req_i,
    input  logic [N_REQ*AW-1:0]       in_add_i,
    input  logic [N_REQ-1:0]          in_wen_i,
    input  logic [N_REQ*(DW/8)-1:0]   in_be_i,
    input  logic [N_REQ*DW-1:0]       in_data_i,
    output logic [N_REQ-1:0]          in_gnt_o,
    output logic [N_REQ*DW-1:0]       in_r_data_o,
    output logic [N_REQ-1:0]          in_r_valid_o,
    // memory side
    output logic                      out_req_o,
    output logic [AW-1:0]             out_add_o,
    output logic                      out_wen_o,
    output logic [DW/8-1:0]           out_be_o,
    output logic [DW-1:0]             out_data_o,
    input  logic                      out_gnt_i,
    input  logic [DW-1:0]             out_r_data_i,
    input  logic                      out_r_valid_i,
    // status
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int unsigned BW  = DW / 8;
    localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CW  = $clog2(MAX_OUTST + 1);

    logic [IDW-1:0] rrPtr_q, rrPtr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  wrPtr_q, wrPtr_d;
    logic [PW-1:0]  rdPtr_q, rdPtr_d;
    logic [IDW-1:0] idFifo_q [MAX_OUTST];
    logic           err_q, err_d;
    logic           drop_q, drop_d;

    logic [IDW-1:0] winner;
    logic           anyReq;
    logic           full;
    logic           accept;
    logic           respHit;
    logic [IDW-1:0] headId;

    // Search starts at the round-robin pointer and wraps; the first requester wins.
    always_comb begin
        logic [IDW:0]   cand;
        logic           found;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rrPtr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N_REQ)) begin
                cand = cand - (IDW+1)'(N_REQ);
            end
            if (!found && in_req_i[cand[IDW-1:0]]) begin
                winner = cand[IDW-1:0];
                found  = 1'b1;
            end
        end
    end

    assign anyReq  = |in_req_i;
    assign full    = (count_q == CW'(MAX_OUTST));
    assign accept  = out_req_o & out_gnt_i;
    assign respHit = out_r_valid_i & (count_q != '0);
    assign headId  = idFifo_q[rdPtr_q];

    assign out_req_o = anyReq & ~full;

    always_comb begin
        out_add_o  = '0;
        out_wen_o  = 1'b0;
        out_be_o   = '0;
        out_data_o = '0;
        if (anyReq) begin
            out_add_o  = in_add_i[winner*AW +: AW];
            out_wen_o  = in_wen_i[winner];
            out_be_o   = in_be_i[winner*BW +: BW];
            out_data_o = in_data_i[winner*DW +: DW];
        end
    end

    always_comb begin
        in_gnt_o     = '0;
        in_r_valid_o = '0;
        if (accept) begin
            in_gnt_o[winner] = 1'b1;
        end
        if (respHit) begin
            in_r_valid_o[headId] = 1'b1;
        end
    end

    assign in_r_data_o = {N_REQ{out_r_data_i}};

    // A response arriving with nothing outstanding is an error, except in the
    // cycle right after reset/clear where a pre-reset response may still land.
    always_comb begin
        rrPtr_d = rrPtr_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        err_d   = err_q;
        drop_d  = 1'b0;
        count_d = count_q + CW'(accept) - CW'(respHit);
        if (accept) begin
            wrPtr_d = wrPtr_q + PW'(1);
            rrPtr_d = (winner == IDW'(N_REQ - 1)) ? '0 : winner + IDW'(1);
        end
        if (respHit) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        if (out_r_valid_i && (count_q == '0) && !drop_q) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            rrPtr_q <= '0;
            count_q <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b1;
        end else begin
            rrPtr_q <= rrPtr_d;
            count_q <= count_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            if (accept) begin
                idFifo_q[wrPtr_q] <= winner;
            end
        end
    end

    assign busy_o = (count_q != '0);
    assign err_o  = err_q;

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Randomized and directed bench for tcdm_rr_arbiter: a reference model predicts
// grants and status each cycle, a scoreboard checks every routed response.
module tb_tcdm_rr_arbiter;

    localparam int N    = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXO = 4;

    logic              clk_i;
    logic              rst_i;
    logic              clear_i;
    logic [N-1:0]      in_req_i;
    logic [N*AW-1:0]   in_add_i;
    logic [N-1:0]      in_wen_i;
    logic [N*BW-1:0]   in_be_i;
    logic [N*DW-1:0]   in_data_i;
    logic [N-1:0]      in_gnt_o;
    logic [N*DW-1:0]   in_r_data_o;
    logic [N-1:0]      in_r_valid_o;
    logic              out_req_o;
    logic [AW-1:0]     out_add_o;
    logic              out_wen_o;
    logic [BW-1:0]     out_be_o;
    logic [DW-1:0]     out_data_o;
    logic              out_gnt_i;
    logic [DW-1:0]     out_r_data_i;
    logic              out_r_valid_i;
    logic              busy_o;
    logic              err_o;

    tcdm_rr_arbiter #(
        .N_REQ     (N),
        .AW        (AW),
        .DW        (DW),
        .MAX_OUTST (MAXO)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .in_req_i      (in_req_i),
        .in_add_i      (in_add_i),
        .in_wen_i      (in_wen_i),
        .in_be_i       (in_be_i),
        .in_data_i     (in_data_i),
        .in_gnt_o      (in_gnt_o),
        .in_r_data_o   (in_r_data_o),
        .in_r_valid_o  (in_r_valid_o),
        .out_req_o     (out_req_o),
        .out_add_o     (out_add_o),
        .out_wen_o     (out_wen_o),
        .out_be_o      (out_be_o),
        .out_data_o    (out_data_o),
        .out_gnt_i     (out_gnt_i),
        .out_r_data_i  (out_r_data_i),
        .out_r_valid_i (out_r_valid_i),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        int             master;
        logic           isRead;
        logic [DW-1:0]  data;
    } exp_t;

    // Master intent, owned by the stimulus process.
    logic [N-1:0]   pend;
    logic [AW-1:0]  pAdd  [N];
    logic           pWen  [N];
    logic [BW-1:0]  pBe   [N];
    logic [DW-1:0]  pData [N];
    logic           gntDrv;
    logic           respEnable;
    logic           finalReq;

    // Model / memory state, owned by the model process.
    logic [N-1:0]   grantedMask = '0;
    int             rr    = 0;
    int             cnt   = 0;
    logic           mErr  = 1'b0;
    logic           mDrop = 1'b1;
    logic [DW-1:0]  memArr [32] = '{default: '0};
    logic [DW-1:0]  refMem [32] = '{default: '0};
    logic [DW-1:0]  memQ [$];
    exp_t           expQ [$];

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus();
        for (int k = 0; k < N; k++) begin
            in_req_i[k]              = pend[k];
            in_add_i[k*AW +: AW]     = pAdd[k];
            in_wen_i[k]              = pWen[k];
            in_be_i[k*BW +: BW]      = pBe[k];
            in_data_i[k*DW +: DW]    = pData[k];
        end
        out_gnt_i     = gntDrv;
        out_r_valid_i = respEnable && (memQ.size() > 0);
        out_r_data_i  = (memQ.size() > 0) ? memQ[0] : DW'($urandom);
    endtask

    task automatic beginCycle();
        @(posedge clk_i);
        #1;
        pend &= ~grantedMask;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            beginCycle();
            applyStimulus();
        end
    endtask

    task automatic setReq(input int k, input logic [AW-1:0] a, input logic wen,
                          input logic [BW-1:0] be, input logic [DW-1:0] d);
        pend[k]  = 1'b1;
        pAdd[k]  = a;
        pWen[k]  = wen;
        pBe[k]   = be;
        pData[k] = d;
    endtask

    task automatic randReq(input int k);
        logic [AW-1:0] a;
        a      = '0;
        a[5:2] = 4'($urandom_range(0, 15));
        setReq(k, a, 1'($urandom_range(0, 1)), BW'($urandom), DW'($urandom));
    endtask

    // Reference model: predicts arbiter outputs from the round-robin rule,
    // and acts as the 1-cycle memory behind the DUT.
    initial begin : modelProc
        int            w;
        logic          expReq;
        logic          acc;
        logic          expHit;
        logic [N-1:0]  expGnt;
        logic [4:0]    word;
        exp_t          e;
        forever begin
            @(negedge clk_i);
            w = -1;
            for (int i = 0; i < N; i++) begin
                if (w < 0 && pend[(rr + i) % N]) w = (rr + i) % N;
            end
            expReq = (w >= 0) && (cnt < MAXO);
            acc    = expReq && out_gnt_i;
            expGnt = '0;
            if (acc) expGnt[w] = 1'b1;
            expHit = out_r_valid_i && (cnt != 0);

            checkOutput("out_req", 64'(out_req_o), 64'(expReq));
            checkOutput("in_gnt", 64'(in_gnt_o), 64'(expGnt));
            checkOutput("rvalid_any", 64'(|in_r_valid_o), 64'(expHit));
            checkOutput("busy", 64'(busy_o), 64'(cnt != 0));
            checkOutput("err", 64'(err_o), 64'(mErr));
            if (w >= 0) begin
                checkOutput("out_add", 64'(out_add_o), 64'(pAdd[w]));
                checkOutput("out_wen", 64'(out_wen_o), 64'(pWen[w]));
                checkOutput("out_be", 64'(out_be_o), 64'(pBe[w]));
                checkOutput("out_data", 64'(out_data_o), 64'(pData[w]));
            end else begin
                checkOutput("out_add_idle", 64'(out_add_o), 64'(0));
            end
            if (finalReq) begin
                checkOutput("pending_drained", 64'(pend), 64'(0));
                checkOutput("scoreboard_empty", 64'(expQ.size()), 64'(0));
            end

            if (out_r_valid_i && memQ.size() > 0) void'(memQ.pop_front());
            if (out_req_o && out_gnt_i) begin
                word = out_add_o[6:2];
                if (out_wen_o) begin
                    memQ.push_back(memArr[word]);
                end else begin
                    for (int b = 0; b < BW; b++) begin
                        if (out_be_o[b]) memArr[word][8*b +: 8] = out_data_o[8*b +: 8];
                    end
                    memQ.push_back('0);
                end
            end

            if (rst_i || clear_i) begin
                rr          = 0;
                cnt         = 0;
                mErr        = 1'b0;
                mDrop       = 1'b1;
                grantedMask = '0;
            end else begin
                if (out_r_valid_i && cnt == 0 && !mDrop) mErr = 1'b1;
                mDrop       = 1'b0;
                grantedMask = '0;
                if (expHit) cnt--;
                if (acc) begin
                    cnt++;
                    rr             = (w + 1) % N;
                    grantedMask[w] = 1'b1;
                    word           = pAdd[w][6:2];
                    e.master       = w;
                    e.isRead       = pWen[w];
                    e.data         = refMem[word];
                    if (!pWen[w]) begin
                        for (int b = 0; b < BW; b++) begin
                            if (pBe[w][b]) refMem[word][8*b +: 8] = pData[w][8*b +: 8];
                        end
                    end
                    expQ.push_back(e);
                end
            end
        end
    end

    // Monitor: every routed response must match the oldest outstanding grant.
    initial begin : monitorProc
        exp_t          e;
        logic [N-1:0]  oh;
        forever begin
            @(negedge clk_i);
            if (rst_i || clear_i) begin
                expQ.delete();
            end else if (in_r_valid_o != '0) begin
                if (expQ.size() == 0) begin
                    checkOutput("rvalid_unexpected", 64'(in_r_valid_o), 64'(0));
                end else begin
                    e = expQ.pop_front();
                    oh = '0;
                    oh[e.master] = 1'b1;
                    checkOutput("rvalid_master", 64'(in_r_valid_o), 64'(oh));
                    if (e.isRead) begin
                        checkOutput("rdata", 64'(in_r_data_o[e.master*DW +: DW]), 64'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        rst_i      = 1'b1;
        clear_i    = 1'b0;
        pend       = '0;
        gntDrv     = 1'b1;
        respEnable = 1'b1;
        finalReq   = 1'b0;
        for (int k = 0; k < N; k++) begin
            pAdd[k]  = '0;
            pWen[k]  = 1'b0;
            pBe[k]   = '0;
            pData[k] = '0;
        end
        applyStimulus();
        idle(3);
        beginCycle();
        rst_i = 1'b0;
        applyStimulus();

        // Lone request from master 2, then masters 1 and 3 together.
        beginCycle();
        setReq(2, 32'h10, 1'b1, 4'hF, 32'h0);
        applyStimulus();
        beginCycle();
        setReq(1, 32'h14, 1'b1, 4'hF, 32'h0);
        setReq(3, 32'h18, 1'b1, 4'hF, 32'h0);
        applyStimulus();
        idle(4);

        // Memory withholds its grant for three cycles.
        beginCycle();
        gntDrv = 1'b0;
        setReq(1, 32'h1C, 1'b1, 4'hF, 32'h0);
        applyStimulus();
        idle(2);
        beginCycle();
        gntDrv = 1'b1;
        applyStimulus();
        idle(3);

        // All masters requesting continuously.
        repeat (10) begin
            beginCycle();
            for (int k = 0; k < N; k++) if (!pend[k]) randReq(k);
            applyStimulus();
        end
        idle(8);

        // Responses withheld until the ID FIFO fills up.
        beginCycle();
        respEnable = 1'b0;
        for (int k = 0; k < N; k++) if (!pend[k]) randReq(k);
        applyStimulus();
        repeat (7) begin
            beginCycle();
            for (int k = 0; k < N; k++) if (!pend[k]) randReq(k);
            applyStimulus();
        end
        beginCycle();
        respEnable = 1'b1;
        applyStimulus();
        idle(14);

        // Partial write from master 0, full read-back from master 3.
        beginCycle();
        setReq(0, 32'h50, 1'b0, 4'b0011, 32'hDEADBEEF);
        applyStimulus();
        idle(3);
        beginCycle();
        setReq(3, 32'h50, 1'b1, 4'hF, 32'h12345678);
        applyStimulus();
        idle(4);

        // Randomized traffic with random memory stalls.
        repeat (400) begin
            beginCycle();
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(0, 2) == 0) randReq(k);
            end
            gntDrv     = ($urandom_range(0, 3) != 0);
            respEnable = ($urandom_range(0, 4) != 0);
            applyStimulus();
        end
        beginCycle();
        gntDrv     = 1'b1;
        respEnable = 1'b1;
        applyStimulus();
        idle(24);

        // Reset with two outstanding, then an in-flight and a spurious response.
        beginCycle();
        respEnable = 1'b0;
        setReq(0, 32'h20, 1'b1, 4'hF, 32'h0);
        setReq(1, 32'h24, 1'b1, 4'hF, 32'h0);
        applyStimulus();
        idle(3);
        beginCycle();
        rst_i = 1'b1;
        applyStimulus();
        beginCycle();
        rst_i      = 1'b0;
        respEnable = 1'b1;
        applyStimulus();
        idle(4);
        beginCycle();
        clear_i = 1'b1;
        applyStimulus();
        beginCycle();
        clear_i = 1'b0;
        applyStimulus();
        idle(3);

        beginCycle();
        finalReq = 1'b1;
        applyStimulus();
        @(negedge clk_i);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
